// File: rtl/id_ex_stage_pkg.sv
// Shared ALU encodings: control codes, ALU-op selectors and R-type funct values.
// Latency: n/a (constants only).
// Backpressure: n/a.
package id_ex_stage_pkg;

    // ALU control codes driven into the ALU
    localparam logic [3:0] CTL_AND = 4'b0000;
    localparam logic [3:0] CTL_OR  = 4'b0001;
    localparam logic [3:0] CTL_ADD = 4'b0010;
    localparam logic [3:0] CTL_SUB = 4'b0110;
    localparam logic [3:0] CTL_SLT = 4'b0111;
    localparam logic [3:0] CTL_NOR = 4'b1100;

    // ALU-op field from the main decoder
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;
    localparam logic [1:0] ALUOP_OR    = 2'b11;

    // R-type funct field values
    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;
    localparam logic [5:0] FUNCT_NOR = 6'b100111;

    // One-entry buffer occupancy states
    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_FULL  = 1'b1;

endpackage

// File: rtl/id_ex_stage_if.sv
// ID/EX bundle: upstream capture handshake, forwarding buses and ALU-side outputs.
// Latency: n/a (wiring only).
// Backpressure: in_ready/out_ready valid-ready pairs carried here.
interface id_ex_stage_if #(
    parameter int WIDTH = 32,
    parameter int RA_W  = 5
);
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [WIDTH-1:0]  in_rs_val;
    logic [WIDTH-1:0]  in_rt_val;
    logic [15:0]       in_imm;
    logic [RA_W-1:0]   in_rs;
    logic [RA_W-1:0]   in_rt;
    logic [RA_W-1:0]   in_rd;
    logic [1:0]        in_alu_op;
    logic [5:0]        in_funct;
    logic              in_alu_src;
    logic              in_reg_write;
    logic              exm_reg_write;
    logic [RA_W-1:0]   exm_rd;
    logic [WIDTH-1:0]  exm_value;
    logic              mwb_reg_write;
    logic [RA_W-1:0]   mwb_rd;
    logic [WIDTH-1:0]  mwb_value;
    logic              out_valid;
    logic              out_ready;
    logic [WIDTH-1:0]  left;
    logic [WIDTH-1:0]  right;
    logic [3:0]        control;
    logic [WIDTH-1:0]  store_data;
    logic [RA_W-1:0]   out_rd;
    logic              out_reg_write;
    logic              illegal;

    // Environment side: feeds instructions and forwarding, consumes ALU operands
    modport master (
        output flush, in_valid, in_rs_val, in_rt_val, in_imm, in_rs, in_rt, in_rd,
               in_alu_op, in_funct, in_alu_src, in_reg_write,
               exm_reg_write, exm_rd, exm_value, mwb_reg_write, mwb_rd, mwb_value,
               out_ready,
        input  in_ready, out_valid, left, right, control, store_data, out_rd,
               out_reg_write, illegal
    );

    // Stage side
    modport slave (
        input  flush, in_valid, in_rs_val, in_rt_val, in_imm, in_rs, in_rt, in_rd,
               in_alu_op, in_funct, in_alu_src, in_reg_write,
               exm_reg_write, exm_rd, exm_value, mwb_reg_write, mwb_rd, mwb_value,
               out_ready,
        output in_ready, out_valid, left, right, control, store_data, out_rd,
               out_reg_write, illegal
    );
endinterface

// File: rtl/id_ex_stage_alu_ctl_decode.sv
// Maps ALU-op plus funct to a 4-bit ALU control code and an illegal-funct flag.
// Latency: combinational.
// Backpressure: none.
module alu_ctl_decode
    import id_ex_stage_pkg::*;
(
    input  logic [1:0] i_alu_op,
    input  logic [5:0] i_funct,
    output logic [3:0] o_control,
    output logic       o_illegal
);

    // Decode; unknown R-type funct falls back to ADD and raises illegal
    always_comb begin
        o_control = CTL_ADD;
        o_illegal = 1'b0;
        case (i_alu_op)
            ALUOP_ADD: o_control = CTL_ADD;
            ALUOP_SUB: o_control = CTL_SUB;
            ALUOP_OR:  o_control = CTL_OR;
            default: begin
                case (i_funct)
                    FUNCT_ADD: o_control = CTL_ADD;
                    FUNCT_SUB: o_control = CTL_SUB;
                    FUNCT_AND: o_control = CTL_AND;
                    FUNCT_OR:  o_control = CTL_OR;
                    FUNCT_SLT: o_control = CTL_SLT;
                    FUNCT_NOR: o_control = CTL_NOR;
                    default: begin
                        o_control = CTL_ADD;
                        o_illegal = 1'b1;
                    end
                endcase
            end
        endcase
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX register: one-entry valid/ready buffer feeding the ALU, with operand forwarding.
// Latency: 1 cycle capture-to-output; full throughput when out_ready is held high.
// Backpressure: in_ready = !out_valid | out_ready, forced low during flush.
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int RA_W   = 5,
    parameter int FWD_EN = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    id_ex_stage_if.slave bus
);

    localparam bit FWD_ON = (FWD_EN != 0);

    logic [0:0]       r_state;
    logic [WIDTH-1:0] r_rs_val;
    logic [WIDTH-1:0] r_rt_val;
    logic [WIDTH-1:0] r_imm_ext;
    logic [RA_W-1:0]  r_rs;
    logic [RA_W-1:0]  r_rt;
    logic [RA_W-1:0]  r_rd;
    logic [3:0]       r_control;
    logic             r_illegal;
    logic             r_alu_src;
    logic             r_reg_write;

    logic             w_full;
    logic             w_in_ready;
    logic             w_capture;
    logic             w_consume;
    logic             w_stall;
    logic [3:0]       w_dec_control;
    logic             w_dec_illegal;
    logic [WIDTH-1:0] w_imm_ext;
    logic             w_exm_rs_hit;
    logic             w_exm_rt_hit;
    logic             w_mwb_rs_hit;
    logic             w_mwb_rt_hit;
    logic [WIDTH-1:0] w_rs_fwd;
    logic [WIDTH-1:0] w_rt_fwd;

    assign w_full     = (r_state == ST_FULL);
    assign w_in_ready = (!w_full || bus.out_ready) && !bus.flush;
    assign w_capture  = bus.in_valid && w_in_ready;
    assign w_consume  = w_full && bus.out_ready;
    assign w_stall    = w_full && !bus.out_ready;
    assign w_imm_ext  = {{(WIDTH-16){bus.in_imm[15]}}, bus.in_imm};

    alu_ctl_decode u_alu_ctl_decode (
        .i_alu_op  (bus.in_alu_op),
        .i_funct   (bus.in_funct),
        .o_control (w_dec_control),
        .o_illegal (w_dec_illegal)
    );

    // Register 0 is hard-wired, so a write to it is never a forwarding source
    assign w_exm_rs_hit = bus.exm_reg_write && (bus.exm_rd != '0) && (bus.exm_rd == r_rs);
    assign w_exm_rt_hit = bus.exm_reg_write && (bus.exm_rd != '0) && (bus.exm_rd == r_rt);
    assign w_mwb_rs_hit = bus.mwb_reg_write && (bus.mwb_rd != '0) && (bus.mwb_rd == r_rs);
    assign w_mwb_rt_hit = bus.mwb_reg_write && (bus.mwb_rd != '0) && (bus.mwb_rd == r_rt);

    // Forward held operands; the younger EX/MEM result wins over MEM/WB
    always_comb begin
        w_rs_fwd = r_rs_val;
        w_rt_fwd = r_rt_val;
        if (FWD_ON) begin
            if (w_exm_rs_hit)      w_rs_fwd = bus.exm_value;
            else if (w_mwb_rs_hit) w_rs_fwd = bus.mwb_value;
            if (w_exm_rt_hit)      w_rt_fwd = bus.exm_value;
            else if (w_mwb_rt_hit) w_rt_fwd = bus.mwb_value;
        end
    end

    // Occupancy and entry capture; flush beats capture, and a stalled entry
    // absorbs MEM/WB writebacks so its operands stay current after the
    // writeback leaves the pipeline
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_EMPTY;
            r_rs_val    <= '0;
            r_rt_val    <= '0;
            r_imm_ext   <= '0;
            r_rs        <= '0;
            r_rt        <= '0;
            r_rd        <= '0;
            r_control   <= CTL_ADD;
            r_illegal   <= 1'b0;
            r_alu_src   <= 1'b0;
            r_reg_write <= 1'b0;
        end else if (bus.flush) begin
            r_state <= ST_EMPTY;
        end else if (w_capture) begin
            r_state     <= ST_FULL;
            r_rs_val    <= bus.in_rs_val;
            r_rt_val    <= bus.in_rt_val;
            r_imm_ext   <= w_imm_ext;
            r_rs        <= bus.in_rs;
            r_rt        <= bus.in_rt;
            r_rd        <= bus.in_rd;
            r_control   <= w_dec_control;
            r_illegal   <= w_dec_illegal;
            r_alu_src   <= bus.in_alu_src;
            r_reg_write <= bus.in_reg_write;
        end else if (w_consume) begin
            r_state <= ST_EMPTY;
        end else if (w_stall && FWD_ON) begin
            if (w_mwb_rs_hit) r_rs_val <= bus.mwb_value;
            if (w_mwb_rt_hit) r_rt_val <= bus.mwb_value;
        end
    end

    assign bus.in_ready      = w_in_ready;
    assign bus.out_valid     = w_full;
    assign bus.left          = w_rs_fwd;
    assign bus.right         = r_alu_src ? r_imm_ext : w_rt_fwd;
    assign bus.control       = r_control;
    assign bus.store_data    = w_rt_fwd;
    assign bus.out_rd        = r_rd;
    assign bus.out_reg_write = r_reg_write && w_full;
    assign bus.illegal       = r_illegal;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: directed instructions push expected ALU-side values,
// a negedge monitor pops and compares on every consume (out_valid & out_ready).
// Direct checks cover reset, stall, flush and bubble-free throughput.
module tb_id_ex_stage;

    typedef struct {
        logic [31:0] left;
        logic [31:0] right;
        logic [31:0] sd;
        logic [3:0]  ctl;
        logic [4:0]  rd;
        logic        rw;
        logic        ill;
    } exp_t;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_bad;
    exp_t exp_q[$];
    exp_t mon_e;
    exp_t none_e;

    id_ex_stage_if #(.WIDTH(32), .RA_W(5)) bus ();

    id_ex_stage #(.WIDTH(32), .RA_W(5), .FWD_EN(1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        n_vec++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, want);
        end
    endtask

    function automatic exp_t mk(input logic [31:0] l, input logic [31:0] r, input logic [31:0] s,
                                input logic [3:0] c, input logic [4:0] d, input logic w,
                                input logic i);
        exp_t e;
        e.left = l; e.right = r; e.sd = s; e.ctl = c; e.rd = d; e.rw = w; e.ill = i;
        return e;
    endfunction

    task automatic drive_in(input logic [31:0] rsv, input logic [31:0] rtv, input logic [15:0] imm,
                            input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                            input logic [1:0] op, input logic [5:0] fn, input logic src,
                            input logic rw);
        bus.in_rs_val = rsv; bus.in_rt_val = rtv; bus.in_imm = imm;
        bus.in_rs = rs; bus.in_rt = rt; bus.in_rd = rd;
        bus.in_alu_op = op; bus.in_funct = fn; bus.in_alu_src = src; bus.in_reg_write = rw;
        bus.in_valid = 1'b1;
    endtask

    // One capture cycle; inputs change at posedge+1 so the edge sees them settled
    task automatic send(input logic [31:0] rsv, input logic [31:0] rtv, input logic [15:0] imm,
                        input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                        input logic [1:0] op, input logic [5:0] fn, input logic src,
                        input logic rw, input bit push, input exp_t e);
        drive_in(rsv, rtv, imm, rs, rt, rd, op, fn, src, rw);
        if (push) exp_q.push_back(e);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic set_fwd(input logic ew, input logic [4:0] erd, input logic [31:0] ev,
                           input logic mw, input logic [4:0] mrd, input logic [31:0] mv);
        bus.exm_reg_write = ew; bus.exm_rd = erd; bus.exm_value = ev;
        bus.mwb_reg_write = mw; bus.mwb_rd = mrd; bus.mwb_value = mv;
    endtask

    // Monitor: compare every consumed entry against the oldest expectation
    always @(negedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL unexpected_out: got output rd=%h with empty scoreboard, want none",
                         bus.out_rd);
            end else begin
                mon_e = exp_q.pop_front();
                check("left",          bus.left,                 mon_e.left);
                check("right",         bus.right,                mon_e.right);
                check("store_data",    bus.store_data,           mon_e.sd);
                check("control",       32'(bus.control),         32'(mon_e.ctl));
                check("out_rd",        32'(bus.out_rd),          32'(mon_e.rd));
                check("out_reg_write", 32'(bus.out_reg_write),   32'(mon_e.rw));
                check("illegal",       32'(bus.illegal),         32'(mon_e.ill));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish by 200000, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0] b2b_fn  [4];
        logic [3:0] b2b_ctl [4];
        b2b_fn[0] = 6'b100000; b2b_ctl[0] = 4'b0010;
        b2b_fn[1] = 6'b100100; b2b_ctl[1] = 4'b0000;
        b2b_fn[2] = 6'b100101; b2b_ctl[2] = 4'b0001;
        b2b_fn[3] = 6'b101010; b2b_ctl[3] = 4'b0111;
        n_vec = 0;
        n_bad = 0;
        none_e = mk(0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b0;
        bus.flush = 1'b0;
        bus.out_ready = 1'b0;
        drive_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        bus.in_valid = 1'b0;
        set_fwd(0, 0, 0, 0, 0, 0);

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid",     32'(bus.out_valid),     32'd0);
        check("rst_control",       32'(bus.control),       32'h2);
        check("rst_left",          bus.left,               32'd0);
        check("rst_right",         bus.right,              32'd0);
        check("rst_store_data",    bus.store_data,         32'd0);
        check("rst_out_rd",        32'(bus.out_rd),        32'd0);
        check("rst_out_reg_write", 32'(bus.out_reg_write), 32'd0);
        check("rst_illegal",       32'(bus.illegal),       32'd0);
        check("rst_in_ready",      32'(bus.in_ready),      32'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        bus.out_ready = 1'b1;

        // Basic R-type SUB
        send(5, 3, 16'h0, 1, 2, 3, 2'b10, 6'b100010, 0, 1, 1, mk(5, 3, 3, 4'b0110, 3, 1, 0));
        tick(1);

        // Forwarding priority: EX/MEM over MEM/WB, then MEM/WB alone, then r0 never forwarded
        set_fwd(1, 8, 32'hAA, 1, 8, 32'hBB);
        send(32'h11, 32'h22, 0, 8, 2, 4, 2'b00, 0, 0, 1, 1, mk(32'hAA, 32'h22, 32'h22, 4'b0010, 4, 1, 0));
        tick(1);
        bus.exm_reg_write = 1'b0;
        send(32'h11, 32'h22, 0, 8, 2, 4, 2'b00, 0, 0, 1, 1, mk(32'hBB, 32'h22, 32'h22, 4'b0010, 4, 1, 0));
        tick(1);
        set_fwd(1, 0, 32'hAA, 1, 0, 32'hBB);
        send(32'h11, 32'h22, 0, 0, 0, 4, 2'b00, 0, 0, 1, 1, mk(32'h11, 32'h22, 32'h22, 4'b0010, 4, 1, 0));
        tick(1);
        // rt path forwards into right and store_data
        set_fwd(1, 6, 32'hAA, 1, 6, 32'hBB);
        send(32'h11, 32'h22, 0, 1, 6, 4, 2'b00, 0, 0, 0, 1, mk(32'h11, 32'hAA, 32'hAA, 4'b0010, 4, 0, 0));
        tick(1);
        set_fwd(0, 0, 0, 0, 0, 0);

        // Stall with a one-cycle MEM/WB pulse; held operand must absorb it
        bus.out_ready = 1'b0;
        send(1, 4, 0, 9, 3, 7, 2'b01, 0, 0, 1, 1, mk(32'h77, 4, 4, 4'b0110, 7, 1, 0));
        @(negedge clk);
        check("stall1_in_ready", 32'(bus.in_ready), 32'd0);
        check("stall1_valid",    32'(bus.out_valid), 32'd1);
        @(posedge clk); #1;
        set_fwd(0, 0, 0, 1, 9, 32'h77);
        @(negedge clk);
        check("stall2_in_ready", 32'(bus.in_ready), 32'd0);
        check("stall2_left",     bus.left, 32'h77);
        @(posedge clk); #1;
        set_fwd(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        check("stall3_in_ready", 32'(bus.in_ready), 32'd0);
        check("stall3_left",     bus.left, 32'h77);
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        tick(1);

        // Back-to-back: one instruction per cycle, no bubbles
        for (int i = 0; i < 4; i++) begin
            send(32'(i + 1), 2, 0, 1, 2, 5'(i + 10), 2'b10, b2b_fn[i], 0, 1, 1,
                 mk(32'(i + 1), 2, 2, b2b_ctl[i], 5'(i + 10), 1, 0));
            if (i < 3) bus.in_valid = 1'b1;
            check("b2b_out_valid", 32'(bus.out_valid), 32'd1);
            check("b2b_in_ready",  32'(bus.in_ready),  32'd1);
        end
        tick(1);

        // Flush beats capture
        bus.out_ready = 1'b0;
        send(32'h55, 32'h66, 0, 1, 2, 3, 2'b00, 0, 0, 1, 0, none_e);
        drive_in(32'h99, 32'h98, 0, 1, 2, 3, 2'b01, 0, 0, 1);
        bus.flush = 1'b1;
        @(negedge clk);
        check("flush_in_ready", 32'(bus.in_ready), 32'd0);
        @(posedge clk); #1;
        bus.flush = 1'b0;
        bus.in_valid = 1'b0;
        check("flush_out_valid", 32'(bus.out_valid), 32'd0);
        tick(1);
        check("flush_no_capture", 32'(bus.out_valid), 32'd0);
        bus.out_ready = 1'b1;

        // Immediate sign extension, OR op, illegal and NOR funct
        send(32'h10, 32'h1234, 16'hFFFC, 1, 2, 3, 2'b00, 0, 1, 1, 1,
             mk(32'h10, 32'hFFFFFFFC, 32'h1234, 4'b0010, 3, 1, 0));
        tick(1);
        send(32'h10, 32'h1234, 16'h8000, 1, 2, 3, 2'b11, 0, 1, 1, 1,
             mk(32'h10, 32'hFFFF8000, 32'h1234, 4'b0001, 3, 1, 0));
        tick(1);
        send(32'h10, 32'h1234, 0, 1, 2, 3, 2'b10, 6'b000001, 0, 1, 1,
             mk(32'h10, 32'h1234, 32'h1234, 4'b0010, 3, 1, 1));
        tick(1);
        send(32'h10, 32'h1234, 0, 1, 2, 3, 2'b10, 6'b100111, 0, 0, 1,
             mk(32'h10, 32'h1234, 32'h1234, 4'b1100, 3, 0, 0));
        tick(1);

        // Reset while stalled discards the held entry
        bus.out_ready = 1'b0;
        send(32'h42, 32'h43, 0, 1, 2, 3, 2'b00, 0, 0, 1, 0, none_e);
        check("midrst_pre_valid", 32'(bus.out_valid), 32'd1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("midrst_out_valid",     32'(bus.out_valid),     32'd0);
        check("midrst_out_reg_write", 32'(bus.out_reg_write), 32'd0);
        bus.out_ready = 1'b1;
        tick(2);

        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register directly upstream of the ALU; it captures a decoded instruction and supplies the ALU's left, right and control inputs.
- Decodes ALU control from a 2-bit ALU-op and 6-bit funct field.
- Applies EX/MEM and MEM/WB operand forwarding.
- One-entry valid/ready buffer with stall and flush, so hazards do not corrupt operands held during a stall.

Parameters:
WIDTH, 32, datapath width of operands and forward buses
RA_W, 5, register-address width
FWD_EN, 1, 1 enables forwarding muxes; 0 passes registered values straight through

Ports:
clk  in  1  clock, all state updates on rising edge
rst_n  in  1  synchronous active-low reset
flush  in  1  kill held entry and block capture this cycle
in_valid  in  1  upstream has an instruction
in_ready  out  1  stage can accept this cycle
in_rs_val  in  WIDTH  register-file value of rs
in_rt_val  in  WIDTH  register-file value of rt
in_imm  in  16  immediate, sign-extended internally
in_rs  in  RA_W  rs index
in_rt  in  RA_W  rt index
in_rd  in  RA_W  destination index
in_alu_op  in  2  00 add, 01 sub, 10 R-type (use funct), 11 or
in_funct  in  6  R-type funct field
in_alu_src  in  1  1 selects sign-extended immediate as right operand
in_reg_write  in  1  instruction writes a register
exm_reg_write  in  1  EX/MEM write enable
exm_rd  in  RA_W  EX/MEM destination
exm_value  in  WIDTH  EX/MEM result
mwb_reg_write  in  1  MEM/WB write enable
mwb_rd  in  RA_W  MEM/WB destination
mwb_value  in  WIDTH  MEM/WB result
out_valid  out  1  left/right/control valid toward ALU
out_ready  in  1  ALU/EX side consumes this cycle
left  out  WIDTH  ALU left operand
right  out  WIDTH  ALU right operand
control  out  4  ALU control code
store_data  out  WIDTH  forwarded rt value, for stores
out_rd  out  RA_W  registered destination
out_reg_write  out  1  registered write enable, qualified by out_valid
illegal  out  1  held R-type funct was unrecognised

Behaviour:
Reset
- On a rising edge with rst_n=0: out_valid=0, illegal=0, all held fields 0.
- Outputs then read left=0, right=0, control=4'b0010, store_data=0, out_rd=0, out_reg_write=0.
- Reset mid-stall discards the held entry.

Handshake and state
- State is EMPTY when out_valid=0 and FULL when out_valid=1.
- in_ready = !out_valid | out_ready, and in_ready is forced to 0 while flush=1.
- Capture occurs when in_valid & in_ready: the entry is loaded and out_valid=1 next cycle.
- Consume without capture: out_valid=0 next cycle.
- Consume and capture in the same cycle: the new entry replaces the old; out_valid stays 1. This gives full throughput with 1-cycle latency.
- flush=1: out_valid=0 next cycle regardless of in_valid or out_ready; flush has priority over capture.

Control decode (at capture, registered)
- alu_op 00 -> 0010; 01 -> 0110; 11 -> 0001.
- alu_op 10, by funct: 100000 -> 0010, 100010 -> 0110, 100100 -> 0000, 100101 -> 0001, 101010 -> 0111, 100111 -> 1100.
- Any other funct -> 0010 and illegal=1.

Immediate
- Sign-extended to WIDTH at capture. 16'h8000 becomes 32'hFFFF8000.

Forwarding (combinational on held entry, FWD_EN=1)
- For source rs: if exm_reg_write & exm_rd!=0 & exm_rd==rs, use exm_value.
- Otherwise, if mwb_reg_write & mwb_rd!=0 & mwb_rd==rs, use mwb_value.
- Otherwise use the held value. EX/MEM has priority over MEM/WB.
- rt uses the same rule, producing store_data.
- left = forwarded rs.
- right = sign-extended imm if alu_src, else forwarded rt.
- Register 0 is never forwarded.

Stall refresh
- While FULL and not consumed, if mwb_reg_write & mwb_rd!=0 & mwb_rd matches held rs (or rt), the held value is overwritten with mwb_value.
- This prevents a stale operand once the writeback retires during the stall.

Decomposition:
- Shared package holds the ALU control codes: CTL_AND=0000, CTL_OR=0001, CTL_ADD=0010, CTL_SUB=0110, CTL_SLT=0111, CTL_NOR=1100.
- The package also holds the ALU-op encodings and funct constants, all shared with the ALU.
- One natural sub-module, alu_ctl_decode: a combinational alu_op/funct -> control/illegal decoder, reusable by other stages.
- The forwarding mux stays inline.

Test Plan:
- Reset and basic pass: rst_n=0 for 2 cycles -> out_valid=0, control=0010. Capture rs_val=5, rt_val=3, alu_op=10, funct=100010, with out_ready=1 -> next cycle out_valid=1, left=5, right=3, control=0110.
- Forwarding priority: held rs=8; exm_rd=8, exm_value=0xAA; mwb_rd=8, mwb_value=0xBB; both reg_write=1 -> left=0xAA. Drop exm_reg_write -> left=0xBB. Repeat with rs=0 -> left=held value.
- Stall and refresh: hold entry rs=9 (value 1) with out_ready=0 for 3 cycles. Pulse mwb_rd=9, mwb_value=0x77 for one cycle; after the pulse ends -> left=0x77, in_ready=0 throughout the stall.
- Back-to-back throughput: in_valid=1 and out_ready=1 for 4 instructions (add, and, or, slt) -> control sequence 0010, 0000, 0001, 0111 on consecutive cycles with no bubbles.
- Flush priority: FULL with in_valid=1 and flush=1 -> next cycle out_valid=0, the new instruction is not captured, in_ready=0 during flush.
- Immediate and illegal: alu_op=00, alu_src=1, imm=16'hFFFC -> right=32'hFFFFFFFC, control=0010. alu_op=10, funct=000001 -> control=0010, illegal=1.
